// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption sequencer: init, one AD block, N PT blocks, final.
// Drives datapath enables and round index; handshakes 64-bit host blocks.
module ascon_ctrl_fsm #(
  parameter int unsigned NUM_PT_BLOCKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic       o_sys_enable,
  output logic       o_mux_select,
  output logic       o_enable_xor_key_begin,
  output logic       o_enable_xor_data_begin,
  output logic       o_enable_xor_key_end,
  output logic       o_enable_xor_lsb_end,
  output logic       o_enable_cipher_reg,
  output logic       o_enable_tag_reg,
  output logic       o_enable_state_reg,
  output logic [3:0] o_round,
  output logic       o_cipher_valid,
  output logic       o_done,
  output logic       o_busy,
  output logic [3:0] o_block_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_AD,
    S_AD,
    S_WAIT_PT,
    S_PT,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_BLK = 4'(NUM_PT_BLOCKS - 1);
  localparam logic [3:0] RND_MAX  = 4'd11;

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] blk_q, blk_d;
  logic       sys_en_q, sys_en_d;
  logic       cval_q, cval_d;

  logic rnd_last;
  logic blk_last;

  assign rnd_last = (round_q == RND_MAX);
  assign blk_last = (blk_q == LAST_BLK);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      round_q  <= '0;
      blk_q    <= '0;
      sys_en_q <= 1'b0;
      cval_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      blk_q    <= blk_d;
      sys_en_q <= sys_en_d;
      cval_q   <= cval_d;
    end
  end

  always_comb begin
    state_d                 = state_q;
    round_d                 = round_q;
    blk_d                   = blk_q;
    sys_en_d                = sys_en_q;
    cval_d                  = 1'b0;
    o_data_ready            = 1'b0;
    o_mux_select            = 1'b0;
    o_enable_xor_key_begin  = 1'b0;
    o_enable_xor_data_begin = 1'b0;
    o_enable_xor_key_end    = 1'b0;
    o_enable_xor_lsb_end    = 1'b0;
    o_enable_cipher_reg     = 1'b0;
    o_enable_tag_reg        = 1'b0;
    o_enable_state_reg      = 1'b0;
    o_round                 = '0;
    o_done                  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_INIT;
          round_d  = '0;
          blk_d    = '0;
          sys_en_d = 1'b1;
        end
      end
      S_INIT: begin
        o_enable_state_reg = 1'b1;
        o_mux_select       = (round_q != 4'd0);
        o_round            = round_q;
        if (rnd_last) begin
          o_enable_xor_key_end = 1'b1;
          state_d              = S_WAIT_AD;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_WAIT_AD: begin
        o_data_ready = 1'b1;
        o_round      = round_q;
        if (i_data_valid) begin
          o_enable_xor_data_begin = 1'b1;
          o_enable_state_reg      = 1'b1;
          o_mux_select            = 1'b1;
          o_round                 = 4'd6;
          round_d                 = 4'd7;
          state_d                 = S_AD;
        end
      end
      S_AD: begin
        o_enable_state_reg = 1'b1;
        o_mux_select       = 1'b1;
        o_round            = round_q;
        if (rnd_last) begin
          // domain separation between AD and PT
          o_enable_xor_lsb_end = 1'b1;
          state_d              = S_WAIT_PT;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_WAIT_PT: begin
        o_data_ready = 1'b1;
        o_round      = round_q;
        if (i_data_valid) begin
          o_enable_xor_data_begin = 1'b1;
          o_enable_cipher_reg     = 1'b1;
          o_enable_state_reg      = 1'b1;
          o_mux_select            = 1'b1;
          blk_d                   = blk_q + 4'd1;
          cval_d                  = 1'b1;
          if (blk_last) begin
            o_enable_xor_key_begin = 1'b1;
            o_round                = 4'd0;
            round_d                = 4'd1;
            state_d                = S_FINAL;
          end else begin
            o_round = 4'd6;
            round_d = 4'd7;
            state_d = S_PT;
          end
        end
      end
      S_PT: begin
        o_enable_state_reg = 1'b1;
        o_mux_select       = 1'b1;
        o_round            = round_q;
        if (rnd_last) begin
          state_d = S_WAIT_PT;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_FINAL: begin
        o_enable_state_reg = 1'b1;
        o_mux_select       = 1'b1;
        o_round            = round_q;
        if (rnd_last) begin
          o_enable_xor_key_end = 1'b1;
          o_enable_tag_reg     = 1'b1;
          state_d              = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        round_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort wins over everything, including a same-cycle transfer
    if (i_abort) begin
      state_d                 = S_IDLE;
      round_d                 = '0;
      blk_d                   = '0;
      sys_en_d                = 1'b0;
      cval_d                  = 1'b0;
      o_data_ready            = 1'b0;
      o_mux_select            = 1'b0;
      o_enable_xor_key_begin  = 1'b0;
      o_enable_xor_data_begin = 1'b0;
      o_enable_xor_key_end    = 1'b0;
      o_enable_xor_lsb_end    = 1'b0;
      o_enable_cipher_reg     = 1'b0;
      o_enable_tag_reg        = 1'b0;
      o_enable_state_reg      = 1'b0;
      o_round                 = '0;
      o_done                  = 1'b0;
    end
  end

  assign o_sys_enable   = sys_en_q;
  assign o_cipher_valid = cval_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_block_count  = blk_q;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: N=4 and N=1 instances against a
// schedule-queue reference model, directed scenarios then random traffic.
module tb_ascon_ctrl_fsm;

  typedef struct packed {
    logic       xkb;
    logic       xdb;
    logic       xke;
    logic       xle;
    logic       cr;
    logic       tr;
    logic       sr;
    logic       mux;
    logic [3:0] rnd;
    logic       rdy;
    logic       done;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic i_start = 1'b0;
  logic i_abort = 1'b0;
  logic i_data_valid = 1'b0;

  logic [1:0] xkb, xdb, xke, xle, cr, tr, sr, mux;
  logic [1:0] rdy, dn, se, cv, bz;
  logic [3:0] rnd [2];
  logic [3:0] bc [2];

  always #5 clock = ~clock;

  ascon_ctrl_fsm #(.NUM_PT_BLOCKS(4)) u0 (
    .clock(clock), .reset(reset),
    .i_start(i_start), .i_abort(i_abort),
    .i_data_valid(i_data_valid),
    .o_data_ready(rdy[0]), .o_sys_enable(se[0]),
    .o_mux_select(mux[0]),
    .o_enable_xor_key_begin(xkb[0]),
    .o_enable_xor_data_begin(xdb[0]),
    .o_enable_xor_key_end(xke[0]),
    .o_enable_xor_lsb_end(xle[0]),
    .o_enable_cipher_reg(cr[0]),
    .o_enable_tag_reg(tr[0]),
    .o_enable_state_reg(sr[0]),
    .o_round(rnd[0]), .o_cipher_valid(cv[0]),
    .o_done(dn[0]), .o_busy(bz[0]),
    .o_block_count(bc[0])
  );

  ascon_ctrl_fsm #(.NUM_PT_BLOCKS(1)) u1 (
    .clock(clock), .reset(reset),
    .i_start(i_start), .i_abort(i_abort),
    .i_data_valid(i_data_valid),
    .o_data_ready(rdy[1]), .o_sys_enable(se[1]),
    .o_mux_select(mux[1]),
    .o_enable_xor_key_begin(xkb[1]),
    .o_enable_xor_data_begin(xdb[1]),
    .o_enable_xor_key_end(xke[1]),
    .o_enable_xor_lsb_end(xle[1]),
    .o_enable_cipher_reg(cr[1]),
    .o_enable_tag_reg(tr[1]),
    .o_enable_state_reg(sr[1]),
    .o_round(rnd[1]), .o_cipher_valid(cv[1]),
    .o_done(dn[1]), .o_busy(bz[1]),
    .o_block_count(bc[1])
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int done_at [2];
  int tag_cnt [2];

  // reference: queue of upcoming per-cycle control vectors
  vec_t mq [2][$];
  bit   busy_m [2];
  bit   sys_m [2];
  bit   cv_m [2];
  bit   ad_m [2];
  int   blk_m [2];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d",
               tag, got, exp, cyc_n);
    end
  endtask

  function automatic int nb(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic vec_t ob(input int k);
    return vec_t'({xkb[k], xdb[k], xke[k], xle[k], cr[k],
                   tr[k], sr[k], mux[k], rnd[k], rdy[k], dn[k]});
  endfunction

  // kind: 0 init, 1 AD, 2 PT, 3 final
  task automatic push_rounds(input int k, input int lo,
                             input int hi, input int kind);
    for (int r = lo; r <= hi; r++) begin
      vec_t v;
      v = '0;
      v.sr  = 1'b1;
      v.mux = (kind != 0) || (r != 0);
      v.rnd = 4'(r);
      if (r == 11) begin
        v.xke = (kind == 0) || (kind == 3);
        v.xle = (kind == 1);
        v.tr  = (kind == 3);
      end
      mq[k].push_back(v);
    end
  endtask

  task automatic model_clear(input int k);
    busy_m[k] = 0;
    sys_m[k]  = 0;
    cv_m[k]   = 0;
    ad_m[k]   = 0;
    blk_m[k]  = 0;
    mq[k].delete();
  endtask

  function automatic vec_t expect_now(input int k, input bit vl);
    vec_t e;
    e = '0;
    if (!busy_m[k]) return e;
    if (mq[k].size() != 0) return mq[k][0];
    e.rdy = 1'b1;
    e.rnd = 4'd11;
    if (vl) begin
      e.xdb = 1'b1;
      e.sr  = 1'b1;
      e.mux = 1'b1;
      e.rnd = 4'd6;
      if (ad_m[k]) begin
        e.cr = 1'b1;
        if (blk_m[k] == nb(k) - 1) begin
          e.xkb = 1'b1;
          e.rnd = 4'd0;
        end
      end
    end
    return e;
  endfunction

  task automatic model_step(input int k, input bit st,
                            input bit vl, input bit ab);
    vec_t v;
    if (ab) begin
      model_clear(k);
      return;
    end
    cv_m[k] = 0;
    if (!busy_m[k]) begin
      if (st) begin
        busy_m[k] = 1;
        sys_m[k]  = 1;
        blk_m[k]  = 0;
        ad_m[k]   = 0;
        push_rounds(k, 0, 11, 0);
      end
    end else if (mq[k].size() != 0) begin
      v = mq[k].pop_front();
      if (v.done) busy_m[k] = 0;
    end else if (vl) begin
      if (!ad_m[k]) begin
        ad_m[k] = 1;
        push_rounds(k, 7, 11, 1);
      end else begin
        blk_m[k]++;
        cv_m[k] = 1;
        if (blk_m[k] == nb(k)) begin
          push_rounds(k, 1, 11, 3);
          v = '0;
          v.done = 1'b1;
          mq[k].push_back(v);
        end else begin
          push_rounds(k, 7, 11, 2);
        end
      end
    end
  endtask

  task automatic check_all(input bit vl, input bit ab);
    for (int k = 0; k < 2; k++) begin
      vec_t o, e;
      string p;
      p = $sformatf("u%0d.", k);
      o = ob(k);
      e = expect_now(k, vl);
      if (ab)
        chk({p, "abort_en"},
            32'({o.xkb, o.xdb, o.xke, o.xle, o.cr, o.tr, o.sr}), 0);
      else
        chk({p, "ctl"}, 32'(o), 32'(e));
      chk({p, "busy"}, 32'(bz[k]), 32'(busy_m[k]));
      chk({p, "sysen"}, 32'(se[k]), 32'(sys_m[k]));
      chk({p, "cvalid"}, 32'(cv[k]), 32'(cv_m[k]));
      chk({p, "blkcnt"}, 32'(bc[k]), 32'(blk_m[k]));
      if (dn[k] === 1'b1 && done_at[k] < 0) done_at[k] = cyc_n;
      if (tr[k] === 1'b1) tag_cnt[k]++;
    end
  endtask

  task automatic cyc(input bit rs, input bit st,
                     input bit vl, input bit ab);
    @(negedge clock);
    reset        = rs;
    i_start      = st;
    i_data_valid = vl;
    i_abort      = ab;
    if (rs) begin
      model_clear(0);
      model_clear(1);
    end
    #1;
    check_all(vl, ab && !rs);
    @(posedge clock);
    if (!rs) begin
      model_step(0, st, vl, ab);
      model_step(1, st, vl, ab);
    end
    cyc_n++;
  endtask

  task automatic clr_marks();
    for (int k = 0; k < 2; k++) begin
      done_at[k] = -1;
      tag_cnt[k] = 0;
    end
  endtask

  int base;

  initial begin
    model_clear(0);
    model_clear(1);
    clr_marks();

    // reset held with start asserted
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);

    // uninterrupted message, valid held high
    clr_marks();
    base = cyc_n;
    for (int i = 0; i < 55; i++) cyc(0, i == 0, 1, 0);
    chk("lat_n4", 32'(done_at[0] - base), 49);
    chk("lat_n1", 32'(done_at[1] - base), 31);
    chk("tags", 32'(tag_cnt[0] + tag_cnt[1]), 2);

    // abort at FINAL round 5 of the N=4 instance
    clr_marks();
    for (int i = 0; i < 46; i++) cyc(0, i == 0, 1, i == 42);
    chk("abort_notag", 32'(tag_cnt[0]), 0);
    chk("abort_nodone", 32'(done_at[0]), 32'(-1));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

    // restart completes normally
    clr_marks();
    base = cyc_n;
    for (int i = 0; i < 55; i++) cyc(0, i == 0, 1, 0);
    chk("relat_n4", 32'(done_at[0] - base), 49);

    // start and abort together in IDLE
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // start during PT ignored, valid withheld 5 cycles in WAIT_PT
    clr_marks();
    base = cyc_n;
    for (int i = 0; i < 62; i++)
      cyc(0, (i == 0) || (i >= 20 && i <= 24), !(i >= 25 && i <= 29), 0);
    chk("stall_lat", 32'(done_at[0] - base), 54);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit rs, st, vl, ab;
      rs = ($urandom_range(999) == 0);
      st = ($urandom_range(7) == 0);
      vl = ($urandom_range(2) != 0);
      ab = ($urandom_range(199) == 0);
      cyc(rs, st, vl, ab);
    end
    cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
